// File: rtl/dso_pkg.sv
// dso_pkg: shared trace RAM geometry and readout FSM state type for the DSO capture/readout blocks.
// No ports; imported by trace_dump and by the capture controller so both agree on RAM geometry.
package dso_pkg;
    localparam int TRACE_DEPTH = 512;
    localparam int TRACE_AW    = 9;
    localparam int SMPL_DW     = 8;
    typedef enum logic [1:0] {IDLE, RD, LAT, SEND} dump_state_t;
endpackage

// File: rtl/trace_dump.sv
// trace_dump: reads the circular trace RAM oldest-sample-first and streams each byte to the host.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   dump_start          one-cycle dump request
//   dump_abort          terminate a dump in progress
//   capture_done        trace buffer holds a complete capture
//   trace_end           address of the newest sample, sampled when a start is accepted
//   rdata               RAM read data, one cycle after ren
//   tx_rdy              transmitter ready
//   raddr, ren          RAM read port
//   tx_data, tx_vld     registered byte to host with its valid
//   dump_busy           high whenever not idle
//   dump_done           pulse on the last accepted byte
//   clr_capture_done    re-arm pulse, coincident with dump_done
//   dump_err            pulse when a start is rejected because no capture is held
module trace_dump
    import dso_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int AW    = TRACE_AW,
    parameter int DW    = SMPL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump_start,
    input  logic          dump_abort,
    input  logic          capture_done,
    input  logic [AW-1:0] trace_end,
    input  logic [DW-1:0] rdata,
    input  logic          tx_rdy,
    output logic [AW-1:0] raddr,
    output logic          ren,
    output logic [DW-1:0] tx_data,
    output logic          tx_vld,
    output logic          dump_busy,
    output logic          dump_done,
    output logic          clr_capture_done,
    output logic          dump_err
);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    dump_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_vld_q, tx_vld_d;
    logic          xfer;

    assign xfer = (state_q == SEND) & tx_vld_q & tx_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        // abort overrides everything, including a handshake completing in the same cycle
        if (state_q != IDLE && dump_abort) begin
            state_d  = IDLE;
            tx_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (dump_start && capture_done && !dump_abort) begin
                    state_d = RD;
                    ptr_d   = trace_end + 1'b1;
                    cnt_d   = '0;
                end
                RD:   state_d = LAT;
                LAT: begin
                    tx_data_d = rdata;
                    tx_vld_d  = 1'b1;
                    state_d   = SEND;
                end
                SEND: if (xfer) begin
                    tx_vld_d = 1'b0;
                    ptr_d    = ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = (cnt_q == LAST) ? IDLE : RD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // pulses are gated by rst_n so a reset cycle never emits done/err
    always_comb begin
        ren              = state_q == RD;
        raddr            = ptr_q;
        dump_busy        = state_q != IDLE;
        dump_done        = rst_n & xfer & ~dump_abort & (cnt_q == LAST);
        clr_capture_done = dump_done;
        dump_err         = rst_n & (state_q == IDLE) & dump_start & ~capture_done;
    end

    assign tx_data = tx_data_q;
    assign tx_vld  = tx_vld_q;
endmodule

// File: tb/tb_trace_dump.sv
// tb_trace_dump: scoreboard bench for trace_dump with a behavioural trace RAM.
// No ports; drives the DUT from directed scenarios and checks reads and bytes in a monitor.
module tb_trace_dump;
    import dso_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0, dump_start = 1'b0, dump_abort = 1'b0;
    logic       capture_done = 1'b1, tx_rdy = 1'b1;
    logic [8:0] trace_end = '0, raddr;
    logic [7:0] rdata, tx_data;
    logic       ren, tx_vld, dump_busy, dump_done, clr_capture_done, dump_err;

    logic [7:0] mem [512];
    logic [8:0] exp_addr [$];
    logic [7:0] exp_data [$];
    int n_chk = 0, n_fail = 0, cyc = 0, acc = 0, done_edge = 0;
    int done_cnt = 0, clr_cnt = 0, err_cnt = 0, nacc = 0;

    trace_dump dut (
        .clk(clk), .rst_n(rst_n), .dump_start(dump_start), .dump_abort(dump_abort),
        .capture_done(capture_done), .trace_end(trace_end), .rdata(rdata), .tx_rdy(tx_rdy),
        .raddr(raddr), .ren(ren), .tx_data(tx_data), .tx_vld(tx_vld), .dump_busy(dump_busy),
        .dump_done(dump_done), .clr_capture_done(clr_capture_done), .dump_err(dump_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (ren) rdata <= mem[raddr];

    function automatic void check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ren) begin
                if (exp_addr.size() == 0) check("unexpected_read", raddr, -1);
                else check("raddr", raddr, exp_addr.pop_front());
                check("ren_while_vld", tx_vld, 0);
            end
            if (tx_vld && tx_rdy) begin
                if (exp_data.size() == 0) check("unexpected_byte", tx_data, -1);
                else check("tx_data", tx_data, exp_data.pop_front());
                nacc++;
            end
            if (dump_done || clr_capture_done) check("clr_eq_done", clr_capture_done, dump_done);
            if (dump_done) begin
                done_cnt++;
                done_edge = cyc + 1;
            end
            if (clr_capture_done) clr_cnt++;
            if (dump_err) err_cnt++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_ren"}, ren, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_vld"}, tx_vld, 0);
        check({tag, "_busy"}, dump_busy, 0);
        check({tag, "_done"}, dump_done, 0);
        check({tag, "_clr"}, clr_capture_done, 0);
        check({tag, "_err"}, dump_err, 0);
    endtask

    // queue the expected reads/bytes, then pulse start; returns just after the accept edge
    task automatic start_dump(input logic [8:0] te, input int nrd, input int ndat);
        for (int k = 0; k < nrd; k++) begin
            logic [8:0] a;
            a = 9'(te + k + 1);
            exp_addr.push_back(a);
            if (k < ndat) exp_data.push_back(mem[a]);
        end
        @(posedge clk); #1;
        trace_end  = te;
        dump_start = 1'b1;
        @(posedge clk); #1;
        acc        = cyc;
        dump_start = 1'b0;
        trace_end  = ~te;
    endtask

    task automatic finish_dump(input int d0, input int exp_len);
        int n = 0;
        while (done_cnt < d0 + 1 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", done_cnt, d0 + 1);
        check("dump_len", done_edge - acc, exp_len);
        check("clr_count", clr_cnt, done_cnt);
        @(negedge clk);
        check("done_one_cycle", dump_done, 0);
        check("idle_after_done", dump_busy, 0);
        check("addr_q_empty", exp_addr.size(), 0);
        check("data_q_empty", exp_data.size(), 0);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (nacc < target && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("acc_reached", nacc >= target, 1);
    endtask

    initial begin
        int d0, c0, base, n;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // full dump; a start while busy must be ignored silently
        d0 = done_cnt;
        start_dump(9'h0FF, 512, 512);
        check("busy_after_accept", dump_busy, 1);
        repeat (20) @(posedge clk);
        #1;
        capture_done = 1'b0;
        dump_start   = 1'b1;
        @(posedge clk); #1;
        dump_start   = 1'b0;
        capture_done = 1'b1;
        finish_dump(d0, 1536);
        check("no_err_while_busy", err_cnt, 0);

        // wrap boundaries
        d0 = done_cnt;
        start_dump(9'h1FF, 512, 512);
        finish_dump(d0, 1536);
        d0 = done_cnt;
        start_dump(9'h000, 512, 512);
        finish_dump(d0, 1536);

        // backpressure on byte 3: expected byte is mem[0x103]
        d0 = done_cnt;
        base = nacc;
        start_dump(9'h0FF, 512, 512);
        wait_acc(base + 3);
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("bp_vld", tx_vld, 1);
                check("bp_data", tx_data, 8'h03);
                check("bp_no_ren", ren, 0);
            end
        end
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        finish_dump(d0, 1541);

        // abort while byte 10 waits in SEND
        d0 = done_cnt;
        c0 = clr_cnt;
        base = nacc;
        start_dump(9'h0AA, 11, 10);
        wait_acc(base + 10);
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        n = 0;
        while (!tx_vld && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_send", tx_vld, 1);
        dump_abort = 1'b1;
        @(posedge clk); #1;
        dump_abort = 1'b0;
        tx_rdy     = 1'b1;
        @(negedge clk);
        check("abort_idle", dump_busy, 0);
        check("abort_vld", tx_vld, 0);
        check("abort_no_done", done_cnt, d0);
        check("abort_no_clr", clr_cnt, c0);
        check("abort_addr_q", exp_addr.size(), 0);
        check("abort_data_q", exp_data.size(), 0);
        start_dump(9'h0AA, 512, 512);
        finish_dump(d0, 1536);

        // rejected start
        capture_done = 1'b0;
        @(posedge clk); #1;
        dump_start = 1'b1;
        @(negedge clk);
        check("rej_err", dump_err, 1);
        check("rej_busy", dump_busy, 0);
        @(posedge clk); #1;
        dump_start = 1'b0;
        @(negedge clk);
        check("rej_err_once", dump_err, 0);
        check("rej_ren", ren, 0);
        check("rej_busy_after", dump_busy, 0);
        check("rej_err_count", err_cnt, 1);
        capture_done = 1'b1;

        // reset during LAT
        d0 = done_cnt;
        start_dump(9'h055, 1, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        check("rst_no_done", done_cnt, d0);
        check("rst_addr_q", exp_addr.size(), 0);
        repeat (4) @(negedge clk);
        check("rst_stays_idle", dump_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
